// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute unit: one-cycle registered multiply and an
// XLEN-iteration restoring divider, stalling the pipeline while it works.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b01011,
    OP_MULH   = 5'b01100,
    OP_MULHSU = 5'b01101,
    OP_MULHU  = 5'b01110,
    OP_DIV    = 5'b01111,
    OP_DIVU   = 5'b10000,
    OP_REM    = 5'b10001,
    OP_REMU   = 5'b10010
  } op_e;

  state_e          state, state_nx;
  op_e             op_q;
  logic [XLEN-1:0] a_q;      // multiplicand, or dividend magnitude shifting into quotient
  logic [XLEN-1:0] b_q;      // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q_q, neg_r_q;

  logic            is_md, is_mul, start;
  logic            in_signed, is_rem_in, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            a_sx, b_sx;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_res;
  logic [XLEN:0]   r_sh, diff;
  logic            ge;
  logic [XLEN-1:0] r_nx, q_nx, quot_fix, rem_fix;

  // Decode the incoming op and decide how a divide would start.
  always_comb begin
    is_md       = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
    is_mul      = (alu_op_i <= OP_MULHU);
    start       = valid_i & is_md & ~flush_i & (state == S_IDLE);
    in_signed   = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    is_rem_in   = (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
    a_neg       = in_signed & src_a_i[XLEN-1];
    b_neg       = in_signed & src_b_i[XLEN-1];
    a_mag       = a_neg ? -src_a_i : src_a_i;
    b_mag       = b_neg ? -src_b_i : src_b_i;
    div_zero    = (src_b_i == '0);
    div_ovf     = in_signed & (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (src_b_i == '1);
    special     = ~is_mul & (div_zero | div_ovf);
    special_res = '0;
    if (div_zero)       special_res = is_rem_in ? src_a_i : '1;
    else if (!is_rem_in) special_res = {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply datapath on latched operands; sign-extend to 2*XLEN then take a half.
  always_comb begin
    a_sx    = (op_q == OP_MUL || op_q == OP_MULH || op_q == OP_MULHSU) & a_q[XLEN-1];
    b_sx    = (op_q == OP_MUL || op_q == OP_MULH) & b_q[XLEN-1];
    product = {{XLEN{a_sx}}, a_q} * {{XLEN{b_sx}}, b_q};
    mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // One restoring-division step plus the sign fixup applied on the last step.
  always_comb begin
    r_sh     = {rem_q, a_q[XLEN-1]};
    diff     = r_sh - {1'b0, b_q};
    ge       = ~diff[XLEN];
    r_nx     = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    q_nx     = {a_q[XLEN-2:0], ge};
    quot_fix = neg_q_q ? -q_nx : q_nx;
    rem_fix  = neg_r_q ? -r_nx : r_nx;
  end

  // Next-state and stall; a flush drops stall in the same cycle.
  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = is_mul ? S_MUL : (special ? S_DONE : S_DIV);
      S_MUL:  state_nx = flush_i ? S_IDLE : S_DONE;
      S_DIV:  if (flush_i) state_nx = S_IDLE;
              else if (cnt_q == '0) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (!rst) stall_o = start | (((state == S_MUL) | (state == S_DIV)) & ~flush_i);
  end

  // State, operand capture, divider iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= op_e'(5'b0);
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      state  <= state_nx;
      busy_o <= (state_nx == S_MUL) || (state_nx == S_DIV);
      done_o <= (state_nx == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          op_q <= op_e'(alu_op_i);
          if (is_mul) begin
            a_q <= src_a_i;
            b_q <= src_b_i;
          end else begin
            a_q     <= a_mag;
            b_q     <= b_mag;
            rem_q   <= '0;
            cnt_q   <= CW'(XLEN - 1);
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            if (special) result_o <= special_res;
          end
        end
        S_MUL: if (!flush_i) result_o <= mul_res;
        S_DIV: if (!flush_i) begin
          a_q   <= q_nx;
          rem_q <= r_nx;
          if (cnt_q == '0)
            result_o <= (op_q == OP_REM || op_q == OP_REMU) ? rem_fix : quot_fix;
          else
            cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized scoreboard bench for muldiv_sequencer with an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [4:0] MUL = 5'b01011, MULH = 5'b01100, MULHSU = 5'b01101, MULHU = 5'b01110;
  localparam logic [4:0] DIV = 5'b01111, DIVU = 5'b10000, REM = 5'b10001, REMU = 5'b10010;

  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i;
  logic [4:0]  alu_op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] t;
    case (op)
      MUL:    begin t = sa * sb; return t[31:0];  end
      MULH:   begin t = sa * sb; return t[63:32]; end
      MULHSU: begin t = sa * ub; return t[63:32]; end
      MULHU:  begin t = ua * ub; return t[63:32]; end
      DIV:    begin if (b == 0) return 32'hFFFFFFFF; t = sa / sb; return t[31:0]; end
      DIVU:   begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      REM:    begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
      REMU:   begin if (b == 0) return a; return a % b; end
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from the start edge to the DONE cycle.
  function automatic int lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op <= MULHU) return 1;
    if (b == 0) return 0;
    if ((op == DIV || op == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    return 32;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int l, n_stall;
    bit got;
    @(negedge clk);
    valid_i = 1'b1; alu_op_i = op; src_a_i = a; src_b_i = b;
    l = lat(op, a, b);
    sb_q.push_back('{model(op, a, b), cyc + 1 + l});
    n_stall = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done_o) begin got = 1'b1; break; end
      if (stall_o) n_stall++;
      @(negedge clk);
    end
    valid_i = 1'b0; alu_op_i = 5'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout op=%b: done_o never seen", op);
    end else begin
      check("stall_cycles", 32'(n_stall), 32'(l + 1));
    end
  endtask

  // Monitor: compare every done_o pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_o) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got result %h expected no done_o", result_o);
        end else begin
          e = sb_q.pop_front();
          check("result", result_o, e.res);
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alu_op_i = 5'b0; src_a_i = '0; src_b_i = '0;
    repeat (2) @(negedge clk);
    valid_i = 1'b1; alu_op_i = DIV; src_a_i = 32'd50; src_b_i = 32'd5;
    #1 check("stall_in_reset", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk);
    valid_i = 1'b0; rst = 1'b0;

    // Directed cases.
    issue(MUL, 32'd7, 32'hFFFFFFFD);
    issue(MULH, 32'h80000000, 32'h80000000);
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    issue(REM, 32'hFFFFFFF9, 32'd2);
    issue(DIVU, 32'd100, 32'd7);
    issue(REMU, 32'd100, 32'd7);
    issue(DIVU, 32'h1234, 32'd0);
    issue(REMU, 32'h1234, 32'd0);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(REM, 32'h80000000, 32'hFFFFFFFF);
    issue(REM, 32'd7, 32'hFFFFFFFE);

    // Non-M and invalid traffic is ignored.
    @(negedge clk);
    valid_i = 1'b1; alu_op_i = 5'b00000; src_a_i = 32'd1; src_b_i = 32'd2;
    #1 check("add_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 check("add_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0; alu_op_i = DIV;
    #1 check("invalid_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 check("invalid_busy", 32'(busy_o), 32'd0);

    // Flush coincident with valid prevents start.
    @(negedge clk);
    valid_i = 1'b1; alu_op_i = MUL; flush_i = 1'b1;
    #1 check("flush_start_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 check("flush_start_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;

    // Flush in cycle 10 of a divide.
    @(negedge clk);
    valid_i = 1'b1; alu_op_i = DIV; src_a_i = 32'd1000; src_b_i = 32'd3;
    repeat (9) @(negedge clk);
    #1 check("div_stall_before_flush", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    #1 check("flush_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 check("flush_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(negedge clk);
    issue(MUL, 32'd3, 32'd5);

    // Reset in cycle 5 of a divide.
    @(negedge clk);
    valid_i = 1'b1; alu_op_i = DIV; src_a_i = 32'hDEADBEEF; src_b_i = 32'd17;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 check("midop_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("midop_rst_busy", 32'(busy_o), 32'd0);
    check("midop_rst_done", 32'(done_o), 32'd0);
    check("midop_rst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    issue(DIVU, 32'd9, 32'd3);

    // Back-to-back multiply then divide.
    issue(MUL, 32'h12345678, 32'h9ABCDEF0);
    issue(DIV, 32'h7FFFFFFF, 32'hFFFFFFF3);

    // Randomized mix including corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(11, 18));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      issue(rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
